fifo_burst_rd_ctrl: RTL and testbench
=====================================

FIFO_BURST_RD_CTRL -- requirements
Module: fifo_burst_rd_ctrl

Interface
REQ-001 The block SHALL have one clock `clk` and an asynchronous, active-low reset `rst_n`.
REQ-002 Parameter BURST_LEN SHALL default to 16 and is the number of 64-bit beats in a full burst (legal range 1..255).
REQ-003 Parameter ADDR_W SHALL default to 28 and is the width of the DDR byte address.
REQ-004 Parameter BASE_ADDR SHALL default to 0 and is the frame start byte address (8-byte aligned).
REQ-005 Parameter FRAME_BEATS SHALL default to 230400 and is the number of beats per frame.
REQ-006 Ports SHALL be:
- clk  in  1  system clock; also drives the FIFO read side.
- rst_n  in  1  asynchronous active-low reset.
- fifo_rd_water_level  in  11  read-side FIFO fill level in 64-bit words.
- fifo_rd_empty  in  1  FIFO empty.
- fifo_rd_data  in  64  FIFO read data; valid 1 cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO read enable.
- ddr_wr_req  out  1  burst request.
- ddr_wr_ack  in  1  request accepted.
- ddr_wr_len  out  8  burst length in beats.
- ddr_wr_addr  out  ADDR_W  burst byte address.
- ddr_wr_data_req  in  1  DDR pulls one beat.
- ddr_wr_data  out  64  beat data; equals fifo_rd_data.
- ddr_wr_done  in  1  burst finished, 1-cycle pulse.
- frame_start  in  1  pulse; restart the address at BASE_ADDR.
- frame_flush  in  1  pulse; drain the FIFO residue.
- busy  out  1  FSM not in IDLE.
- frame_done  out  1  1-cycle pulse when a flush completes.
- underflow_err  out  1  sticky error flag.

Function
REQ-007 The FSM SHALL have the states IDLE, REQ, DATA and WAIT_DONE; busy SHALL be 1 in every state except IDLE.
REQ-008 IDLE SHALL behave as follows:
- If level >= BURST_LEN: latch len = BURST_LEN and go to REQ.
- Else if flush_pend and level > 0: latch len = level[7:0] and go to REQ.
- Else if flush_pend and level == 0: pulse frame_done, clear flush_pend, stay in IDLE.
REQ-009 In REQ, ddr_wr_req SHALL be held at 1 and ddr_wr_len and ddr_wr_addr SHALL be held stable until ddr_wr_ack is sampled high, then the FSM SHALL go to DATA with beat_cnt = 0.
REQ-010 In DATA, fifo_rd_en SHALL equal ddr_wr_data_req && (beat_cnt < len), combinationally; every asserted fifo_rd_en SHALL increment beat_cnt.
REQ-011 When beat_cnt reaches len, the FSM SHALL go to WAIT_DONE; any further ddr_wr_data_req SHALL NOT assert fifo_rd_en.
REQ-012 ddr_wr_data SHALL equal fifo_rd_data with no added register; the DDR port samples it 1 cycle after ddr_wr_data_req.
REQ-013 In WAIT_DONE, on ddr_wr_done the block SHALL:
- add len to beat_ptr and update ddr_wr_addr = BASE_ADDR + beat_ptr*8;
- wrap beat_ptr to 0 when it is >= FRAME_BEATS, so the address returns to BASE_ADDR;
- go to IDLE.
REQ-014 A frame_flush pulse SHALL set flush_pend in any state; flush_pend SHALL clear only via REQ-008.
REQ-015 A frame_start pulse SHALL set start_pend; start_pend SHALL be applied (beat_ptr = 0, start_pend cleared) only on a cycle in IDLE with no transition to REQ, so an in-flight burst is never re-addressed.
REQ-016 If frame_start and ddr_wr_done coincide, the WAIT_DONE address update SHALL occur first, and start_pend SHALL be applied on the next qualifying IDLE cycle.
REQ-017 Any cycle with fifo_rd_en = 1 and fifo_rd_empty = 1 SHALL set underflow_err, which stays set until reset; the read is still issued.
REQ-018 The block SHALL NOT gate on wr_full, and SHALL NOT issue a request while len == 0.

Reset
REQ-019 While rst_n = 0, all outputs SHALL be 0 except ddr_wr_addr = BASE_ADDR and ddr_wr_data, which follows fifo_rd_data.
REQ-020 Reset SHALL put the FSM in IDLE and clear beat_ptr, beat_cnt, len, flush_pend, start_pend and underflow_err.
REQ-021 Reset asserted mid-burst SHALL abort at once with no further fifo_rd_en.
REQ-022 Release of rst_n SHALL be synchronised internally.

Verification
REQ-023 Full burst: level = 16 -> ddr_wr_req asserts, len = 16, addr = 0; ack -> exactly 16 fifo_rd_en; done -> addr = 0x80.
REQ-024 Flush: level = 5 with frame_flush -> burst with len = 5; after done and level = 0 -> a single frame_done pulse.
REQ-025 Wrap: FRAME_BEATS = 32, two full bursts -> the third burst uses addr = BASE_ADDR.
REQ-026 Extra pulls: ddr_wr_data_req held for 20 cycles with len = 16 -> 16 fifo_rd_en only.
REQ-027 frame_start during DATA -> the current burst keeps its address; the next burst uses BASE_ADDR.
REQ-028 Empty read: level forced to 16 with fifo_rd_empty = 1 -> underflow_err = 1 until rst_n = 0.

Source files
------------

// File: rtl/fifo_burst_rd_ctrl.sv
// Burst read controller: drains a read-side FIFO into fixed-length DDR write bursts,
// walks a frame-relative address that wraps at FRAME_BEATS, and flushes FIFO residue on request.
module fifo_burst_rd_ctrl #(
  parameter int              BURST_LEN   = 16,
  parameter int              ADDR_W      = 28,
  parameter longint unsigned BASE_ADDR   = 0,
  parameter int              FRAME_BEATS = 230400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       fifo_rd_water_level,
  input  logic              fifo_rd_empty,
  input  logic [63:0]       fifo_rd_data,
  output logic              fifo_rd_en,
  output logic              ddr_wr_req,
  input  logic              ddr_wr_ack,
  output logic [7:0]        ddr_wr_len,
  output logic [ADDR_W-1:0] ddr_wr_addr,
  input  logic              ddr_wr_data_req,
  output logic [63:0]       ddr_wr_data,
  input  logic              ddr_wr_done,
  input  logic              frame_start,
  input  logic              frame_flush,
  output logic              busy,
  output logic              frame_done,
  output logic              underflow_err
);

  // Pointer must hold beat_ptr + len before the wrap compare.
  localparam int                PTR_W     = $clog2(FRAME_BEATS + 256);
  localparam logic [PTR_W-1:0]  FRAME_END = PTR_W'(FRAME_BEATS);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
  localparam logic [10:0]       BURST_LVL = 11'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, REQ, DATA, WAIT_DONE} state_t;

  state_t           state, state_d;
  logic [1:0]       rst_sync;
  logic             rst_int_n;
  logic [7:0]       len;
  logic [7:0]       beat_cnt;
  logic [PTR_W-1:0] beat_ptr;
  logic [PTR_W-1:0] ptr_sum;
  logic             flush_pend;
  logic             start_pend;
  logic             burst_full;
  logic             burst_flush;
  logic             start_apply;

  // NOTE: reset asserts asynchronously but releases only after two clock edges, so no
  // flop sees a reset deassertion close to its clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign burst_full  = fifo_rd_water_level >= BURST_LVL;
  assign burst_flush = flush_pend && (fifo_rd_water_level != 11'd0);
  // A pending frame restart is taken only on an idle cycle that launches no burst.
  assign start_apply = (state == IDLE) && start_pend && !(burst_full || burst_flush);
  assign ptr_sum     = beat_ptr + PTR_W'(len);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= IDLE;
    else            state <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (burst_full || burst_flush)                state_d = REQ;
      REQ:       if (ddr_wr_ack)                               state_d = DATA;
      DATA:      if (fifo_rd_en && (beat_cnt + 8'd1 == len))   state_d = WAIT_DONE;
      WAIT_DONE: if (ddr_wr_done)                              state_d = IDLE;
      default:                                                 state_d = IDLE;
    endcase
  end

  always_comb begin
    ddr_wr_req = 1'b0;
    busy       = 1'b1;
    fifo_rd_en = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        frame_done = flush_pend && !burst_full && (fifo_rd_water_level == 11'd0);
      end
      REQ:  ddr_wr_req = 1'b1;
      DATA: fifo_rd_en = ddr_wr_data_req && (beat_cnt < len);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      len           <= '0;
      beat_cnt      <= '0;
      beat_ptr      <= '0;
      flush_pend    <= 1'b0;
      start_pend    <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (burst_full)       len <= 8'(BURST_LEN);
        else if (burst_flush) len <= fifo_rd_water_level[7:0];
      end

      if (state == REQ && ddr_wr_ack) beat_cnt <= '0;
      else if (fifo_rd_en)            beat_cnt <= beat_cnt + 8'd1;

      if (state == WAIT_DONE && ddr_wr_done)
        beat_ptr <= (ptr_sum >= FRAME_END) ? '0 : ptr_sum;
      else if (start_apply)
        beat_ptr <= '0;

      if (frame_flush)     flush_pend <= 1'b1;
      else if (frame_done) flush_pend <= 1'b0;

      if (frame_start)      start_pend <= 1'b1;
      else if (start_apply) start_pend <= 1'b0;

      if (fifo_rd_en && fifo_rd_empty) underflow_err <= 1'b1;
    end
  end

  assign ddr_wr_len  = len;
  assign ddr_wr_addr = BASE_A + (ADDR_W'(beat_ptr) << 3);
  assign ddr_wr_data = fifo_rd_data;

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// Directed bench for fifo_burst_rd_ctrl with a 32-beat frame so address wrap is reachable.
module tb_fifo_burst_rd_ctrl;

  localparam int ADDR_W = 28;

  logic              clk;
  logic              rst_n;
  logic [10:0]       fifo_rd_water_level;
  logic              fifo_rd_empty;
  logic [63:0]       fifo_rd_data;
  logic              fifo_rd_en;
  logic              ddr_wr_req;
  logic              ddr_wr_ack;
  logic [7:0]        ddr_wr_len;
  logic [ADDR_W-1:0] ddr_wr_addr;
  logic              ddr_wr_data_req;
  logic [63:0]       ddr_wr_data;
  logic              ddr_wr_done;
  logic              frame_start;
  logic              frame_flush;
  logic              busy;
  logic              frame_done;
  logic              underflow_err;

  int checks   = 0;
  int failures = 0;

  fifo_burst_rd_ctrl #(
    .BURST_LEN  (16),
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (0),
    .FRAME_BEATS(32)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fifo_rd_water_level(fifo_rd_water_level),
    .fifo_rd_empty      (fifo_rd_empty),
    .fifo_rd_data       (fifo_rd_data),
    .fifo_rd_en         (fifo_rd_en),
    .ddr_wr_req         (ddr_wr_req),
    .ddr_wr_ack         (ddr_wr_ack),
    .ddr_wr_len         (ddr_wr_len),
    .ddr_wr_addr        (ddr_wr_addr),
    .ddr_wr_data_req    (ddr_wr_data_req),
    .ddr_wr_data        (ddr_wr_data),
    .ddr_wr_done        (ddr_wr_done),
    .frame_start        (frame_start),
    .frame_flush        (frame_flush),
    .busy               (busy),
    .frame_done         (frame_done),
    .underflow_err      (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits up to 40 cycles for a burst request; returns sampled at negedge + 1.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (ddr_wr_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_ack();
    ddr_wr_ack = 1'b1;
    @(negedge clk);
    ddr_wr_ack = 1'b0;
  endtask

  // Holds ddr_wr_data_req for 'pulls' cycles, counting reads and data passthrough errors.
  task automatic do_pulls(input int pulls, output int n_rd, output int bad);
    n_rd = 0;
    bad  = 0;
    for (int i = 0; i < pulls; i++) begin
      ddr_wr_data_req = 1'b1;
      fifo_rd_data    = {$urandom, $urandom};
      #1;
      if (fifo_rd_en) n_rd++;
      if (ddr_wr_data !== fifo_rd_data) bad++;
      @(negedge clk);
    end
    ddr_wr_data_req = 1'b0;
    #1;
  endtask

  task automatic do_done();
    ddr_wr_done = 1'b1;
    @(negedge clk);
    ddr_wr_done = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    fifo_rd_data        = 64'hDEAD_BEEF_0123_4567;
    fifo_rd_water_level = 11'd16;
    ddr_wr_data_req     = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({fifo_rd_en, ddr_wr_req, busy, frame_done, underflow_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 00000",
               {fifo_rd_en, ddr_wr_req, busy, frame_done, underflow_err});
    end
    checks++;
    if (ddr_wr_len !== 8'd0) begin
      failures++;
      $display("FAIL reset_len: got %0d required 0", ddr_wr_len);
    end
    checks++;
    if (ddr_wr_addr !== 28'h0) begin
      failures++;
      $display("FAIL reset_addr: got %0h required 0", ddr_wr_addr);
    end
    checks++;
    if (ddr_wr_data !== 64'hDEAD_BEEF_0123_4567) begin
      failures++;
      $display("FAIL reset_data_follow: got %0h required deadbeef01234567", ddr_wr_data);
    end
    ddr_wr_data_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_sync_release: busy got %b required 0", busy);
    end
    fifo_rd_water_level = 11'd0;
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_full_burst();
    bit ok;
    bit stable_bad;
    int n_rd, bad;
    fifo_rd_water_level = 11'd16;
    wait_req(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL full_req_timeout: req got 0 required 1");
    end
    checks++;
    if (ddr_wr_len !== 8'd16 || ddr_wr_addr !== 28'h0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL full_req_fields: len=%0d addr=%0h busy=%b required 16/0/1",
               ddr_wr_len, ddr_wr_addr, busy);
    end
    stable_bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (ddr_wr_req !== 1'b1 || ddr_wr_len !== 8'd16 || ddr_wr_addr !== 28'h0) stable_bad = 1'b1;
    end
    checks++;
    if (stable_bad !== 1'b0) begin
      failures++;
      $display("FAIL full_req_hold: unstable got 1 required 0");
    end
    fifo_rd_water_level = 11'd0;
    do_ack();
    do_pulls(16, n_rd, bad);
    checks++;
    if (n_rd !== 16) begin
      failures++;
      $display("FAIL full_rd_count: got %0d required 16", n_rd);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL full_data_passthrough: errors got %0d required 0", bad);
    end
    checks++;
    if (busy !== 1'b1 || ddr_wr_req !== 1'b0) begin
      failures++;
      $display("FAIL full_wait_done: busy=%b req=%b required 1/0", busy, ddr_wr_req);
    end
    do_done();
    checks++;
    if (ddr_wr_addr !== 28'h80 || busy !== 1'b0 || underflow_err !== 1'b0) begin
      failures++;
      $display("FAIL full_after_done: addr=%0h busy=%b uf=%b required 80/0/0",
               ddr_wr_addr, busy, underflow_err);
    end
  endtask

  task automatic test_extra_pulls();
    bit ok;
    int n_rd, bad;
    fifo_rd_water_level = 11'd16;
    wait_req(ok);
    checks++;
    if (!ok || ddr_wr_addr !== 28'h80) begin
      failures++;
      $display("FAIL extra_req: ok=%b addr=%0h required 1/80", ok, ddr_wr_addr);
    end
    fifo_rd_water_level = 11'd0;
    do_ack();
    do_pulls(20, n_rd, bad);
    checks++;
    if (n_rd !== 16) begin
      failures++;
      $display("FAIL extra_rd_count: got %0d required 16", n_rd);
    end
    do_done();
  endtask

  task automatic test_wrap();
    checks++;
    if (ddr_wr_addr !== 28'h0) begin
      failures++;
      $display("FAIL wrap_addr: got %0h required 0", ddr_wr_addr);
    end
  endtask

  task automatic test_flush();
    bit ok;
    int n_rd, bad, n_done;
    fifo_rd_water_level = 11'd5;
    frame_flush = 1'b1;
    @(negedge clk);
    frame_flush = 1'b0;
    wait_req(ok);
    checks++;
    if (!ok || ddr_wr_len !== 8'd5 || ddr_wr_addr !== 28'h0) begin
      failures++;
      $display("FAIL flush_req: ok=%b len=%0d addr=%0h required 1/5/0", ok, ddr_wr_len, ddr_wr_addr);
    end
    do_ack();
    do_pulls(5, n_rd, bad);
    checks++;
    if (n_rd !== 5) begin
      failures++;
      $display("FAIL flush_rd_count: got %0d required 5", n_rd);
    end
    fifo_rd_water_level = 11'd0;
    do_done();
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (frame_done) n_done++;
      @(negedge clk); #1;
    end
    checks++;
    if (n_done !== 1) begin
      failures++;
      $display("FAIL flush_frame_done: pulses got %0d required 1", n_done);
    end
    checks++;
    if (ddr_wr_addr !== 28'h28 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_after: addr=%0h busy=%b required 28/0", ddr_wr_addr, busy);
    end
  endtask

  task automatic test_start_mid_burst();
    bit ok;
    int n1, n2, bad;
    fifo_rd_water_level = 11'd16;
    wait_req(ok);
    checks++;
    if (!ok || ddr_wr_addr !== 28'h28) begin
      failures++;
      $display("FAIL start_req: ok=%b addr=%0h required 1/28", ok, ddr_wr_addr);
    end
    fifo_rd_water_level = 11'd0;
    do_ack();
    do_pulls(4, n1, bad);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    checks++;
    if (ddr_wr_addr !== 28'h28 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_hold_addr: addr=%0h busy=%b required 28/1", ddr_wr_addr, busy);
    end
    do_pulls(12, n2, bad);
    checks++;
    if (n1 + n2 !== 16) begin
      failures++;
      $display("FAIL start_rd_count: got %0d required 16", n1 + n2);
    end
    do_done();
    checks++;
    if (ddr_wr_addr !== 28'hA8) begin
      failures++;
      $display("FAIL start_done_addr: got %0h required a8", ddr_wr_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (ddr_wr_addr !== 28'h0) begin
      failures++;
      $display("FAIL start_applied: got %0h required 0", ddr_wr_addr);
    end
  endtask

  task automatic test_start_with_done();
    bit ok;
    int n_rd, bad;
    fifo_rd_water_level = 11'd16;
    wait_req(ok);
    fifo_rd_water_level = 11'd0;
    do_ack();
    do_pulls(16, n_rd, bad);
    ddr_wr_done = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    ddr_wr_done = 1'b0;
    frame_start = 1'b0;
    #1;
    checks++;
    if (!ok || ddr_wr_addr !== 28'h80) begin
      failures++;
      $display("FAIL coincide_update_first: ok=%b addr=%0h required 1/80", ok, ddr_wr_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (ddr_wr_addr !== 28'h0) begin
      failures++;
      $display("FAIL coincide_start_applied: got %0h required 0", ddr_wr_addr);
    end
  endtask

  task automatic test_underflow_and_abort();
    bit ok;
    int n_rd, bad;
    fifo_rd_empty       = 1'b1;
    fifo_rd_water_level = 11'd16;
    wait_req(ok);
    fifo_rd_water_level = 11'd0;
    do_ack();
    do_pulls(3, n_rd, bad);
    checks++;
    if (!ok || underflow_err !== 1'b1) begin
      failures++;
      $display("FAIL underflow_set: ok=%b uf=%b required 1/1", ok, underflow_err);
    end
    fifo_rd_empty = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (underflow_err !== 1'b1) begin
      failures++;
      $display("FAIL underflow_sticky: got %b required 1", underflow_err);
    end
    ddr_wr_data_req = 1'b1;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre_read: rd_en got %b required 1", fifo_rd_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({fifo_rd_en, busy, ddr_wr_req, underflow_err} !== 4'b0 || ddr_wr_len !== 8'd0 ||
        ddr_wr_addr !== 28'h0) begin
      failures++;
      $display("FAIL abort_reset: rd_en=%b busy=%b req=%b uf=%b len=%0d addr=%0h required all 0",
               fifo_rd_en, busy, ddr_wr_req, underflow_err, ddr_wr_len, ddr_wr_addr);
    end
    ddr_wr_data_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || underflow_err !== 1'b0) begin
      failures++;
      $display("FAIL abort_recover: busy=%b uf=%b required 0/0", busy, underflow_err);
    end
  endtask

  initial begin
    rst_n               = 1'b0;
    fifo_rd_water_level = 11'd0;
    fifo_rd_empty       = 1'b0;
    fifo_rd_data        = 64'h0;
    ddr_wr_ack          = 1'b0;
    ddr_wr_data_req     = 1'b0;
    ddr_wr_done         = 1'b0;
    frame_start         = 1'b0;
    frame_flush         = 1'b0;

    test_reset();
    test_full_burst();
    test_extra_pulls();
    test_wrap();
    test_flush();
    test_start_mid_burst();
    test_start_with_done();
    test_underflow_and_abort();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
